// File: rtl/mmio_pkg.sv
// mmio_pkg: I/O base, register selects, CTRL bit indices and active-low hex-to-7-segment decode
package mmio_pkg;
  localparam logic [31:0] IO_BASE = 32'h8000_0000;
  localparam logic [2:0] OFF_LED = 3'd0;
  localparam logic [2:0] OFF_SW = 3'd1;
  localparam logic [2:0] OFF_COUNT = 3'd2;
  localparam logic [2:0] OFF_CTRL = 3'd3;
  localparam logic [2:0] OFF_CMP = 3'd4;
  localparam logic [2:0] OFF_SEG = 3'd5;
  localparam int CTRL_EN = 0;
  localparam int CTRL_FLAG = 1;
  localparam int CTRL_AUTO = 2;
  function automatic logic [6:0] hex7seg(input logic [3:0] d);
    case (d)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction
endpackage

// File: rtl/seg7_scan.sv
// seg7_scan: 8-digit multiplexed 7-segment driver; clk, reset, value in -> an, seg out (active low)
module seg7_scan
  import mmio_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] value,
  output logic [7:0]  an,
  output logic [6:0]  seg
);
  localparam int CW = $clog2(SCAN_DIV);
  logic [CW-1:0] scan_q, scan_d;
  logic [2:0] idx_q, idx_d;
  logic wrap;
  always_comb begin
    wrap = scan_q == CW'(SCAN_DIV - 1);
    scan_d = wrap ? '0 : scan_q + CW'(1);
    idx_d = wrap ? idx_q + 3'd1 : idx_q;
    an = ~(8'd1 << idx_q);
    seg = hex7seg(value[{idx_q, 2'b00} +: 4]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_q <= '0;
      idx_q <= '0;
    end else begin
      scan_q <= scan_d;
      idx_q <= idx_d;
    end
  end
endmodule

// File: rtl/dmem_mmio.sv
// dmem_mmio: word RAM plus LED/SW/timer/7-seg MMIO; bus memwrite, addr, writedata -> readdata; sw in; led, an, seg, timer_irq out
module dmem_mmio
  import mmio_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        timer_irq
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] ram_idx;
  logic [2:0] sel;
  logic io_wr, ram_wr, match;
  logic [15:0] led_q, led_d, sw1_q, sw2_q;
  logic [31:0] count_q, count_d, cmp_q, cmp_d, seg_q, seg_d;
  logic en_q, en_d, flag_q, flag_d, auto_q, auto_d;
  always_comb begin
    ram_idx = addr[AW+1:2];
    sel = addr[4:2];
    io_wr = memwrite & addr[31];
    ram_wr = memwrite & ~addr[31];
    match = en_q && count_q == cmp_q;
    led_d = io_wr && sel == OFF_LED ? writedata[15:0] : led_q;
    cmp_d = io_wr && sel == OFF_CMP ? writedata : cmp_q;
    seg_d = io_wr && sel == OFF_SEG ? writedata : seg_q;
    en_d = io_wr && sel == OFF_CTRL ? writedata[CTRL_EN] : en_q;
    auto_d = io_wr && sel == OFF_CTRL ? writedata[CTRL_AUTO] : auto_q;
    // a match in the same cycle wins over write-1-to-clear
    flag_d = match | (flag_q & ~(io_wr && sel == OFF_CTRL && writedata[CTRL_FLAG]));
    // bus write overrides the timer; match already used the pre-write count
    count_d = io_wr && sel == OFF_COUNT ? writedata :
              match && auto_q ? '0 : count_q + {31'b0, en_q};
  end
  always_comb begin
    readdata = '0;
    if (!addr[31]) readdata = mem[ram_idx];
    else case (sel)
      OFF_LED: readdata = {16'b0, led_q};
      OFF_SW: readdata = {16'b0, sw2_q};
      OFF_COUNT: readdata = count_q;
      OFF_CTRL: readdata = {29'b0, auto_q, flag_q, en_q};
      OFF_CMP: readdata = cmp_q;
      OFF_SEG: readdata = seg_q;
      default: readdata = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      led_q <= '0;
      sw1_q <= '0;
      sw2_q <= '0;
      count_q <= '0;
      cmp_q <= '1;
      seg_q <= '0;
      en_q <= 1'b0;
      flag_q <= 1'b0;
      auto_q <= 1'b0;
    end else begin
      led_q <= led_d;
      sw1_q <= sw;
      sw2_q <= sw1_q;
      count_q <= count_d;
      cmp_q <= cmp_d;
      seg_q <= seg_d;
      en_q <= en_d;
      flag_q <= flag_d;
      auto_q <= auto_d;
    end
  end
  always_ff @(posedge clk) if (ram_wr && !reset) mem[ram_idx] <= writedata;
  assign led = led_q;
  assign timer_irq = flag_q;
  seg7_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk(clk),
    .reset(reset),
    .value(seg_q),
    .an(an),
    .seg(seg)
  );
endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: randomized and directed checks of dmem_mmio against a behavioural model
module tb_dmem_mmio;
  import mmio_pkg::*;
  localparam int DEPTH = 64;
  localparam int SCAN_DIV = 4;
  logic clk = 1'b0;
  logic reset, memwrite, timer_irq;
  logic [31:0] addr, writedata, readdata;
  logic [15:0] sw, led;
  logic [7:0] an;
  logic [6:0] seg;
  int errors = 0;
  int checks = 0;
  dmem_mmio #(.DEPTH(DEPTH), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk),
    .reset(reset),
    .memwrite(memwrite),
    .addr(addr),
    .writedata(writedata),
    .readdata(readdata),
    .sw(sw),
    .led(led),
    .an(an),
    .seg(seg),
    .timer_irq(timer_irq)
  );
  always #5 clk = ~clk;
  logic [31:0] m_ram [DEPTH];
  bit m_val [DEPTH];
  logic [15:0] m_led, m_s1, m_s2;
  logic [31:0] m_count, m_cmp, m_seg;
  bit m_en, m_flag, m_auto;
  int m_cyc;
  logic [6:0] hexlut [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic void model_reset();
    m_led = 0;
    m_s1 = 0;
    m_s2 = 0;
    m_count = 0;
    m_cmp = 32'hFFFF_FFFF;
    m_seg = 0;
    m_en = 0;
    m_flag = 0;
    m_auto = 0;
    m_cyc = 0;
  endfunction
  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (!a[31]) return m_ram[a[7:2]];
    case (a[4:2])
      3'd0: return {16'b0, m_led};
      3'd1: return {16'b0, m_s2};
      3'd2: return m_count;
      3'd3: return {29'b0, m_auto, m_flag, m_en};
      3'd4: return m_cmp;
      3'd5: return m_seg;
      default: return 32'h0;
    endcase
  endfunction
  task automatic step(input logic r, input logic we, input logic [31:0] a, input logic [31:0] wd);
    int i;
    bit hit;
    logic [7:0] ea;
    reset = r;
    memwrite = we;
    addr = a;
    writedata = wd;
    #1;
    if (a[31] || m_val[a[7:2]]) chk("readdata", readdata, model_read(a));
    chk("led", {16'b0, led}, {16'b0, m_led});
    chk("irq", {31'b0, timer_irq}, {31'b0, m_flag});
    i = (m_cyc / SCAN_DIV) % 8;
    ea = ~(8'd1 << i);
    chk("an", {24'b0, an}, {24'b0, ea});
    chk("seg", {25'b0, seg}, {25'b0, hexlut[m_seg[4*i +: 4]]});
    @(posedge clk);
    if (r) model_reset();
    else begin
      hit = m_en && (m_count == m_cmp);
      if (m_en) m_count = (hit && m_auto) ? 32'h0 : m_count + 1;
      if (hit) m_flag = 1;
      if (we && !a[31]) begin
        m_ram[a[7:2]] = wd;
        m_val[a[7:2]] = 1;
      end
      if (we && a[31]) begin
        if (a[4:2] == 3'd0) m_led = wd[15:0];
        if (a[4:2] == 3'd2) m_count = wd;
        if (a[4:2] == 3'd3) begin
          m_en = wd[0];
          m_auto = wd[2];
          if (wd[1] && !hit) m_flag = 0;
        end
        if (a[4:2] == 3'd4) m_cmp = wd;
        if (a[4:2] == 3'd5) m_seg = wd;
      end
      m_s2 = m_s1;
      m_s1 = sw;
      m_cyc++;
    end
    @(negedge clk);
  endtask
  task automatic peek(input logic [31:0] a);
    memwrite = 1'b0;
    addr = a;
    #1;
  endtask
  initial begin
    logic [31:0] a, wd;
    reset = 1'b1;
    memwrite = 1'b0;
    addr = 0;
    writedata = 0;
    sw = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    chk("rst_an", {24'b0, an}, 32'hFE);
    chk("rst_seg", {25'b0, seg}, 32'h40);
    chk("rst_led", {16'b0, led}, 32'h0);
    chk("rst_irq", {31'b0, timer_irq}, 32'h0);
    peek(IO_BASE + 32'h10);
    chk("rst_cmp", readdata, 32'hFFFF_FFFF);
    step(0, 1, 32'h10, 32'hDEADBEEF);
    step(0, 0, 32'h13, 0);
    peek(32'h110);
    chk("ram_alias", readdata, 32'hDEADBEEF);
    step(0, 1, IO_BASE, 32'h1234ABCD);
    chk("led_val", {16'b0, led}, 32'hABCD);
    peek(IO_BASE);
    chk("led_read", readdata, 32'h0000ABCD);
    sw = 16'h00F0;
    repeat (3) step(0, 0, IO_BASE + 4, 0);
    peek(IO_BASE + 4);
    chk("sw_sync", readdata, 32'hF0);
    step(0, 1, IO_BASE + 32'h10, 3);
    step(0, 1, IO_BASE + 32'hC, 32'h5);
    repeat (9) step(0, 0, IO_BASE + 8, 0);
    step(0, 1, IO_BASE + 32'hC, 32'h7);
    repeat (6) step(0, 0, IO_BASE + 32'hC, 0);
    step(0, 1, IO_BASE + 8, 32'hFFFF_FFF0);
    peek(IO_BASE + 8);
    chk("cnt_write_wins", readdata, 32'hFFFF_FFF0);
    step(1, 0, 0, 0);
    step(0, 1, IO_BASE + 8, 32'hFFFF_FFFD);
    step(0, 1, IO_BASE + 32'hC, 32'h1);
    repeat (5) step(0, 0, IO_BASE + 8, 0);
    chk("wrap_irq", {31'b0, timer_irq}, 32'h1);
    step(1, 0, 0, 0);
    step(0, 1, IO_BASE + 32'h14, 32'h8F);
    repeat (40) step(0, 0, IO_BASE + 32'h14, 0);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) sw = 16'($urandom);
      if ($urandom_range(0, 1) == 1) a = {1'b0, 31'($urandom)};
      else a = IO_BASE | ($urandom & 32'h7FFF_FFE3) | (32'($urandom_range(0, 7)) << 2);
      wd = $urandom_range(0, 1) == 1 ? 32'($urandom_range(0, 15)) : $urandom;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0, a, wd);
    end
    step(1, 0, 0, 0);
    step(0, 1, IO_BASE, 32'hFFFF);
    step(0, 1, IO_BASE + 32'hC, 32'h1);
    repeat (3) step(0, 0, IO_BASE + 8, 0);
    step(1, 1, IO_BASE, 32'h1234);
    chk("mid_rst_led", {16'b0, led}, 32'h0);
    chk("mid_rst_an", {24'b0, an}, 32'hFE);
    chk("mid_rst_seg", {25'b0, seg}, 32'h40);
    chk("mid_rst_irq", {31'b0, timer_irq}, 32'h0);
    peek(IO_BASE + 8);
    chk("mid_rst_count", readdata, 32'h0);
    repeat (3) step(0, 0, IO_BASE + 8, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-memory and memory-mapped I/O stage directly downstream of the single-cycle datapath: it consumes the ALU result as the address, the store data and the controller's `memwrite`, and returns `readdata` to the datapath's result mux within the same cycle. It holds a word RAM, an LED register, a synchronised switch input, a 32-bit compare timer with interrupt flag, and an 8-digit multiplexed 7-segment display driver.

## Interface
Parameters:
- `DEPTH`, 64: RAM words; power of two.
- `SCAN_DIV`, 100000: clock cycles per display digit; must be ≥ 2.

Ports:
- `clk`  in  1  Rising-edge clock; only clock.
- `reset`  in  1  Synchronous, active-high reset.
- `memwrite`  in  1  Store strobe from the controller.
- `addr`  in  32  Byte address (datapath `aluout`).
- `writedata`  in  32  Store data.
- `readdata`  out  32  Load data, combinational from `addr`.
- `sw`  in  16  Asynchronous board switches.
- `led`  out  16  LED register.
- `an`  out  8  Digit enables, active low.
- `seg`  out  7  Segments `{g,f,e,d,c,b,a}`, active low.
- `timer_irq`  out  1  Timer flag (CTRL bit 1).

## Operation
- `addr[1:0]` is ignored; all accesses are whole words.
- Decode:
  - `addr[31]=0` → RAM, index `addr[$clog2(DEPTH)+1:2]`; upper bits alias.
  - `addr[31]=1` → I/O, register select `addr[4:2]`.
- I/O registers (offsets from 0x8000_0000):
  - 0x00 LED: RW, bits [15:0]; reads zero-extended.
  - 0x04 SW: RO; 2-flop-synchronised `sw`, zero-extended.
  - 0x08 COUNT: RW.
  - 0x0C CTRL: bit0 EN (RW), bit1 FLAG (read; write 1 clears), bit2 AUTO (RW).
  - 0x10 CMP: RW.
  - 0x14 SEG: RW, 8 hex digits; digit *i* = bits [4i+3:4i].
  - 0x18, 0x1C: unmapped; read 0, writes ignored.
- Writes to RO fields and unmapped offsets are ignored.
- Timer, per cycle with EN=1:
  - If COUNT==CMP: FLAG←1, and COUNT←0 if AUTO else COUNT+1.
  - Otherwise COUNT←COUNT+1.
  - Wraps modulo 2^32.
- Timer with EN=0: COUNT holds; no compare.
- Simultaneous events:
  - Bus write to COUNT beats increment/reload; the compare uses the pre-write COUNT.
  - FLAG set beats write-1-clear in the same cycle.
- Display:
  - Scan counter counts 0..SCAN_DIV−1; on wrap, digit index 0..7 increments mod 8.
  - `an` = ~(1<<idx).
  - `seg` = active-low hex decode of SEG digit idx (0→7'b1000000, 8→7'b0000000, F→7'b0001110).

## Timing
- `readdata`: combinational, same cycle as `addr`; no wait states.
- Writes (RAM and registers): take effect at the rising edge where `memwrite`=1; visible to reads the following cycle.
- SW read reflects a `sw` change after 2 edges.
- `timer_irq` rises the cycle after the matching edge's compare, i.e. it is registered FLAG.
- `an`/`seg`: combinational from registered idx and SEG; a SEG write shows on the next cycle.
- Reset values:
  - LED=0, COUNT=0, CTRL=0, CMP=0xFFFF_FFFF, SEG=0.
  - Sync flops=0, scan counter=0, idx=0.
  - Hence `led`=0, `timer_irq`=0, `an`=8'hFE, `seg`=7'b1000000.
- RAM is not reset; contents are undefined until written.
- Reset mid-operation: reset beats any simultaneous write. Timer and scan restart from 0.

## Structure
- Package `mmio_pkg`:
  - `IO_BASE`.
  - Register offset constants.
  - CTRL bit indices.
  - `hex7seg` function (4→7 active-low).
- Sub-module `seg7_scan`:
  - Inputs: `clk`, `reset`, 32-bit value.
  - Outputs: `an`, `seg`.
  - Parameter: `SCAN_DIV`.
- RAM, registers, timer and decode live in `dmem_mmio`.

## Test plan
- **RAM:** write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0013 → 0xDEADBEEF. Read 0x0000_0110 with DEPTH=64 → same word (aliasing).
- **LED/SW:** write 0x1234ABCD to 0x8000_0000 → `led`=0xABCD, read 0x0000ABCD. Set `sw`=0x00F0 → SW reads 0 for 2 cycles, then 0x000000F0.
- **Timer AUTO:**
  - Setup: CMP=3, CTRL=0b101.
  - Response: COUNT sequence 1,2,3,0,1…; `timer_irq` rises the cycle after COUNT reads 3.
  - Write CTRL=0b111 → FLAG clears unless a match occurs that cycle.
- **Timer collision:**
  - Write COUNT=0xFFFF_FFF0 while EN=1 → next cycle COUNT=0xFFFF_FFF0 (write wins).
  - With EN=1, CMP left at reset 0xFFFF_FFFF, AUTO=0: COUNT runs to 0xFFFF_FFFF, FLAG=1, then wraps to 0.
- **Display:**
  - Setup: SCAN_DIV=4, SEG=0x0000008F.
  - Response: `an`=FE/`seg`=0001110 for 4 cycles, then FD/0000000, then FB/1000000; after 32 cycles back to FE.
- **Reset mid-run:** with timer running and `led`=0xFFFF, assert `reset` for 1 cycle concurrent with an LED write → all outputs return to reset values; the LED write is lost.
